// File: rtl/magma_soc.sv
module magma_soc #(
    parameter string CPU      = "riscv_5stage",
    parameter string mem_init = "NO",
    parameter string mem_data = "",
    parameter int    mem_size = 1024,
    parameter int    clk_div  = 434
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        rx_i,
    output logic        tx_o,
    input  logic [31:0] gpio_bi,
    output logic [31:0] gpio_bo
);
    localparam int AW = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam int CW = $clog2(clk_div + 1);
    localparam logic [7:0] SYNC = 8'h55;
    localparam logic [7:0] ESC  = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_LEN, S_WDATA, S_RREQ, S_RWAIT, S_RSEND
    } state_t;

    if (CPU == "") begin : g_cpu_reserved
    end

    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic          rx_busy_reg, rx_valid_reg;
    logic [3:0]    rx_bit_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [7:0]    rx_shift_reg, rx_data_reg;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_busy_reg  <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_bit_reg   <= '0;
            rx_cnt_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
        end else begin
            rx_meta_reg  <= rx_i;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_valid_reg <= 1'b0;
            if (!rx_busy_reg) begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_busy_reg <= 1'b1;
                    rx_bit_reg  <= '0;
                    rx_cnt_reg  <= CW'(clk_div / 2 - 1);
                end
            end else if (rx_cnt_reg != '0) begin
                rx_cnt_reg <= rx_cnt_reg - 1'b1;
            end else begin
                rx_cnt_reg <= CW'(clk_div - 1);
                rx_bit_reg <= rx_bit_reg + 4'd1;
                if (rx_bit_reg == 4'd0) begin
                    if (rx_sync_reg) rx_busy_reg <= 1'b0;
                end else if (rx_bit_reg <= 4'd8) begin
                    rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                end else begin
                    rx_busy_reg <= 1'b0;
                    if (rx_sync_reg) begin
                        rx_valid_reg <= 1'b1;
                        rx_data_reg  <= rx_shift_reg;
                    end
                end
            end
        end
    end

    logic esc_reg;
    logic is_sync, is_data;
    assign is_sync = rx_valid_reg && !esc_reg && (rx_data_reg == SYNC);
    assign is_data = rx_valid_reg && (esc_reg || ((rx_data_reg != SYNC) && (rx_data_reg != ESC)));

    logic [7:0]    fifo_mem [8];
    logic [3:0]    fifo_wp_reg, fifo_rp_reg;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_din;
    logic          tx_reg, tx_busy_reg;
    logic [8:0]    tx_shift_reg;
    logic [3:0]    tx_bits_reg;
    logic [CW-1:0] tx_cnt_reg;

    assign fifo_empty = (fifo_wp_reg == fifo_rp_reg);
    assign fifo_full  = (fifo_wp_reg[2:0] == fifo_rp_reg[2:0]) && (fifo_wp_reg[3] != fifo_rp_reg[3]);
    assign fifo_pop   = !tx_busy_reg && !fifo_empty;
    assign tx_o       = tx_reg;

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem[fifo_wp_reg[2:0]] <= fifo_din;
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            fifo_wp_reg  <= '0;
            fifo_rp_reg  <= '0;
            tx_reg       <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_shift_reg <= '0;
            tx_bits_reg  <= '0;
            tx_cnt_reg   <= '0;
        end else begin
            if (fifo_push) fifo_wp_reg <= fifo_wp_reg + 4'd1;
            if (fifo_pop) begin
                fifo_rp_reg  <= fifo_rp_reg + 4'd1;
                tx_busy_reg  <= 1'b1;
                tx_reg       <= 1'b0;
                tx_shift_reg <= {1'b1, fifo_mem[fifo_rp_reg[2:0]]};
                tx_bits_reg  <= 4'd9;
                tx_cnt_reg   <= CW'(clk_div - 1);
            end else if (tx_busy_reg) begin
                if (tx_cnt_reg != '0) begin
                    tx_cnt_reg <= tx_cnt_reg - 1'b1;
                end else if (tx_bits_reg != 4'd0) begin
                    tx_reg       <= tx_shift_reg[0];
                    tx_shift_reg <= {1'b0, tx_shift_reg[8:1]};
                    tx_bits_reg  <= tx_bits_reg - 4'd1;
                    tx_cnt_reg   <= CW'(clk_div - 1);
                end else begin
                    tx_busy_reg <= 1'b0;
                end
            end
        end
    end

    logic [31:0] ram [mem_size];
    logic        bus_we_reg, bus_we_next, bus_re_reg, bus_re_next;
    logic [31:0] bus_addr_reg, bus_addr_next, bus_wdata_reg, bus_wdata_next;
    logic [31:0] ram_rdata_reg, io_rdata_reg, gpio_reg, bus_rdata;
    logic        rd_ram_reg, rd_valid_reg, soft_rst_reg, soft_rst_next;
    logic        ram_sel, gpo_sel, gpi_sel;

    assign ram_sel   = bus_addr_reg < 32'(4 * mem_size);
    assign gpo_sel   = bus_addr_reg[31:2] == 30'h2000_0000;
    assign gpi_sel   = bus_addr_reg[31:2] == 30'h2000_0001;
    assign bus_rdata = rd_ram_reg ? ram_rdata_reg : io_rdata_reg;
    assign gpio_bo   = gpio_reg;

    always_ff @(posedge clk_i) begin
        if (bus_we_reg && ram_sel) ram[bus_addr_reg[AW+1:2]] <= bus_wdata_reg;
        ram_rdata_reg <= ram[bus_addr_reg[AW+1:2]];
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            gpio_reg     <= '0;
            io_rdata_reg <= '0;
            rd_ram_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus_re_reg;
            if (soft_rst_reg)                 gpio_reg <= '0;
            else if (bus_we_reg && gpo_sel)   gpio_reg <= bus_wdata_reg;
            if (bus_re_reg) begin
                rd_ram_reg   <= ram_sel;
                io_rdata_reg <= gpo_sel ? gpio_reg : (gpi_sel ? gpio_bi : 32'h0);
            end
        end
    end

    state_t      state_reg, state_next;
    logic [1:0]  bcnt_reg, bcnt_next;
    logic [31:0] addr_reg, addr_next, len_reg, len_next, word_reg, word_next;
    logic [7:0]  cmd_reg, cmd_next, tx_byte;
    logic        txesc_reg, txesc_next, addr_inc, is_write;

    assign addr_inc = (cmd_reg == 8'h81) || (cmd_reg == 8'h82);
    assign is_write = (cmd_reg == 8'h81) || (cmd_reg == 8'h83);
    assign tx_byte  = word_reg[{bcnt_reg, 3'b000} +: 8];

    always_comb begin
        state_next     = state_reg;
        bcnt_next      = bcnt_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        word_next      = word_reg;
        cmd_next       = cmd_reg;
        txesc_next     = txesc_reg;
        soft_rst_next  = soft_rst_reg;
        bus_we_next    = 1'b0;
        bus_re_next    = 1'b0;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        fifo_push      = 1'b0;
        fifo_din       = tx_byte;
        if (is_sync) begin
            state_next = S_CMD;
            bcnt_next  = '0;
            txesc_next = 1'b0;
        end else begin
            case (state_reg)
                S_CMD: if (is_data) begin
                    cmd_next  = rx_data_reg;
                    bcnt_next = '0;
                    case (rx_data_reg)
                        8'h00: begin
                            word_next  = 32'h0000_0055;
                            len_next   = 32'd1;
                            txesc_next = 1'b0;
                            state_next = S_RSEND;
                        end
                        8'h80: begin soft_rst_next = 1'b1; state_next = S_IDLE; end
                        8'hC0: begin soft_rst_next = 1'b0; state_next = S_IDLE; end
                        8'h81, 8'h82, 8'h83, 8'h84: state_next = S_ADDR;
                        default: state_next = S_IDLE;
                    endcase
                end
                S_ADDR: if (is_data) begin
                    addr_next = {rx_data_reg, addr_reg[31:8]};
                    bcnt_next = bcnt_reg + 2'd1;
                    if (bcnt_reg == 2'd3) state_next = S_LEN;
                end
                S_LEN: if (is_data) begin
                    len_next  = {rx_data_reg, len_reg[31:8]};
                    bcnt_next = bcnt_reg + 2'd1;
                    if (bcnt_reg == 2'd3) begin
                        if (len_next == 32'd0) state_next = S_IDLE;
                        else if (is_write)     state_next = S_WDATA;
                        else                   state_next = S_RREQ;
                    end
                end
                S_WDATA: if (is_data) begin
                    word_next = {rx_data_reg, word_reg[31:8]};
                    bcnt_next = bcnt_reg + 2'd1;
                    len_next  = len_reg - 32'd1;
                    if (bcnt_reg == 2'd3) begin
                        bus_we_next    = 1'b1;
                        bus_addr_next  = addr_reg;
                        bus_wdata_next = word_next;
                        if (addr_inc) addr_next = addr_reg + 32'd4;
                    end
                    if (len_reg == 32'd1) state_next = S_IDLE;
                end
                S_RREQ: begin
                    bus_re_next   = 1'b1;
                    bus_addr_next = addr_reg;
                    bcnt_next     = '0;
                    txesc_next    = 1'b0;
                    state_next    = S_RWAIT;
                end
                S_RWAIT: if (rd_valid_reg) begin
                    word_next  = bus_rdata;
                    state_next = S_RSEND;
                end
                S_RSEND: if (!fifo_full) begin
                    fifo_push = 1'b1;
                    if (((tx_byte == SYNC) || (tx_byte == ESC)) && !txesc_reg) begin
                        fifo_din   = ESC;
                        txesc_next = 1'b1;
                    end else begin
                        txesc_next = 1'b0;
                        bcnt_next  = bcnt_reg + 2'd1;
                        len_next   = len_reg - 32'd1;
                        if (len_reg == 32'd1) begin
                            state_next = S_IDLE;
                        end else if (bcnt_reg == 2'd3) begin
                            state_next = S_RREQ;
                            if (addr_inc) addr_next = addr_reg + 32'd4;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_reg     <= S_IDLE;
            bcnt_reg      <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            word_reg      <= '0;
            cmd_reg       <= '0;
            txesc_reg     <= 1'b0;
            soft_rst_reg  <= 1'b0;
            esc_reg       <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_re_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            bcnt_reg      <= bcnt_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            word_reg      <= word_next;
            cmd_reg       <= cmd_next;
            txesc_reg     <= txesc_next;
            soft_rst_reg  <= soft_rst_next;
            bus_we_reg    <= bus_we_next;
            bus_re_reg    <= bus_re_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            if (rx_valid_reg) esc_reg <= !esc_reg && (rx_data_reg == ESC);
        end
    end
endmodule

// File: tb/tb_magma_soc.sv
// Directed bench for magma_soc: bit-bangs UDM frames into rx_i and decodes tx_o.
module tb_magma_soc;
    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [31:0] gpio_in = 32'h0;
    logic [31:0] gpio_out;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rxq [$];

    magma_soc #(.clk_div(DIV)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .rx_i   (rx),
        .tx_o   (tx),
        .gpio_bi(gpio_in),
        .gpio_bo(gpio_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Independent UART decoder on tx_o, samples mid-bit on the falling clock edge.
    initial begin : tx_monitor
        logic [7:0] b;
        wait (arst === 1'b1);
        forever begin
            @(negedge tx);
            repeat (DIV / 2) @(negedge clk);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                rxq.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (DIV) @(posedge clk);
        end
    endtask

    task automatic send_lit(input logic [7:0] b);
        if (b == 8'h55 || b == 8'h5A) send_byte(8'h5A);
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_lit(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] len);
        $display("txn cmd %h addr %h len %0d", cmd, addr, len);
        send_byte(8'h55);
        send_byte(cmd);
        send_word(addr);
        send_word(len);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (rxq.size() == 0 && n < 30 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (rxq.size() == 0) check_eq({tag, "_timeout"}, 32'h100, {24'h0, exp});
        else                 check_eq(tag, {24'h0, rxq.pop_front()}, {24'h0, exp});
    endtask

    // Expected device-side bytes for the low nbytes of a word, with escaping.
    task automatic expect_word(input string tag, input logic [31:0] w, input int nbytes);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = w[8*i +: 8];
            if (b == 8'h55 || b == 8'h5A) expect_byte({tag, "_esc"}, 8'h5A);
            expect_byte($sformatf("%s_b%0d", tag, i), b);
        end
    endtask

    initial begin
        arst = 1'b0;
        repeat (6) @(posedge clk);
        arst = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tx", {31'h0, tx}, 32'h1);
        check_eq("reset_gpio", gpio_out, 32'h0);

        $display("txn IDCODE");
        send_byte(8'h55);
        send_byte(8'h00);
        expect_byte("idcode_esc", 8'h5A);
        expect_byte("idcode", 8'h55);

        send_hdr(8'h81, 32'h0, 32'd4);
        send_word(32'h1234_55AA);
        send_hdr(8'h82, 32'h0, 32'd4);
        expect_word("ram_rd", 32'h1234_55AA, 4);

        gpio_in = 32'h30;
        send_hdr(8'h81, 32'h8000_0000, 32'd4);
        send_word(32'h5AAA_5AAA);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("gpio_wr", gpio_out, 32'h5AAA_5AAA);
        send_hdr(8'h82, 32'h8000_0004, 32'd4);
        expect_word("gpio_in", 32'h0000_0030, 4);

        $display("txn RST");
        send_byte(8'h55);
        send_byte(8'h80);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("softrst_gpio", gpio_out, 32'h0);
        $display("txn nRST");
        send_byte(8'h55);
        send_byte(8'hC0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("nrst_gpio", gpio_out, 32'h0);
        send_hdr(8'h82, 32'h0, 32'd4);
        expect_word("ram_keep", 32'h1234_55AA, 4);

        send_hdr(8'h81, 32'h10, 32'd8);
        send_word(32'd1);
        send_word(32'd2);
        send_hdr(8'h82, 32'h10, 32'd8);
        expect_word("burst_w0", 32'd1, 4);
        expect_word("burst_w1", 32'd2, 4);

        send_hdr(8'h83, 32'h20, 32'd8);
        send_word(32'd3);
        send_word(32'd4);
        send_hdr(8'h82, 32'h20, 32'd4);
        expect_word("noinc_wr", 32'd4, 4);
        send_hdr(8'h84, 32'h10, 32'd8);
        expect_word("noinc_rd0", 32'd1, 4);
        expect_word("noinc_rd1", 32'd1, 4);

        send_hdr(8'h82, 32'h4000_0000, 32'd4);
        expect_word("unmapped", 32'd0, 4);

        // Three trailing bytes must not overwrite the word; a 2-byte read returns the low half.
        send_hdr(8'h81, 32'h30, 32'd4);
        send_word(32'h1122_3344);
        send_hdr(8'h81, 32'h30, 32'd3);
        send_lit(8'hFF);
        send_lit(8'hFF);
        send_lit(8'hFF);
        send_hdr(8'h82, 32'h30, 32'd2);
        expect_word("partial", 32'h1122_3344, 2);

        repeat (40 * DIV) @(posedge clk);
        @(negedge clk);
        check_eq("no_extra_bytes", rxq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
